draw_image_ctl: RTL
===================

DRAW_IMAGE_CTL -- requirements
Module: draw_image_ctl

Interface
REQ-001 Parameter IMG_W, default 64, image width in pixels; fixed at 64 by the 6-bit x address field.
REQ-002 Parameter IMG_H, default 64, image height in pixels; fixed at 64 by the 6-bit y address field.
REQ-003 Parameter KEY_RGB, default 12'hF0F, transparent colour key.
REQ-004 clk  input  1  system/pixel clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 hcount_in, vcount_in  input  11 each  VGA pixel counters.
REQ-007 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  VGA timing strobes.
REQ-008 rgb_in  input  12  upstream background pixel.
REQ-009 xpos, ypos  input  11 each  requested top-left image corner, any cycle.
REQ-010 address  output  12  ROM address {y[5:0], x[5:0]}, registered.
REQ-011 rgb_rom  input  12  ROM data, valid one clk after address.
REQ-012 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  output  11/11/1/1/1/1  timing delayed 3 clk.
REQ-013 rgb_out  output  12  composited pixel, aligned with delayed timing.

Function
REQ-014 Position latch: xpos/ypos SHALL be captured into xpos_q/ypos_q only on the cycle vsync_in rises (vsync_in=1, prior sampled value 0); no other update.
REQ-015 Stage 1 (edge E1): register timing, rgb_in, in_win flag and address from inputs sampled at E1.
REQ-016 in_win = (hcount_in >= xpos_q) and (hcount_in < xpos_q+IMG_W) and (vcount_in >= ypos_q) and (vcount_in < ypos_q+IMG_H); sums computed in 12 bits, no wrap.
REQ-017 address = {(vcount_in-ypos_q)[5:0], (hcount_in-xpos_q)[5:0]} when in_win, else 12'h000.
REQ-018 Stage 2 (E2): delay timing, rgb_in and in_win one more clk; ROM concurrently produces rgb_rom.
REQ-019 Stage 3 (E3): rgb_out = 12'h000 if hblnk or vblnk (stage-2 copy) is 1; else rgb_rom if in_win and rgb_rom != KEY_RGB; else delayed rgb_in.
REQ-020 Total latency input→rgb_out and timing outputs SHALL be exactly 3 clk, fully pipelined, one pixel per clk.
REQ-021 Image partly off-screen (xpos_q+64 > 1023 etc.) SHALL draw only visible pixels; no wrapped duplicates.
REQ-022 vsync rise coinciding with xpos/ypos change SHALL latch the new values; pixels from that same cycle already in the pipeline use old values.

Reset
REQ-023 While rst_n=0: all pipeline registers, address, xpos_q, ypos_q, vsync edge register and all outputs SHALL be 0, asynchronously.
REQ-024 After rst_n rises, outputs SHALL follow inputs after 3 clk; first latch needs a vsync rise (position 0,0 until then).
REQ-025 Reset asserted mid-line SHALL clear immediately; no partial pixels emitted after release except from newly sampled inputs.

Verification
REQ-026 rst_n=0 for 5 clk with random inputs -> all outputs 0, address 0.
REQ-027 Latched xpos=100, ypos=50; hcount=100, vcount=50 -> address 12'h000 next clk; hcount=163, vcount=113 -> 12'hFFF; hcount=164 -> in_win 0, rgb_out=rgb_in 3 clk later.
REQ-028 rgb_rom=12'hF0F inside window, rgb_in=12'h123 -> rgb_out=12'h123; rgb_rom=12'hABC -> 12'hABC; hblnk_in=1 -> 12'h000.
REQ-029 Change xpos 100→200 mid-frame -> window unchanged until next vsync rising edge, then at 200.
REQ-030 xpos=1000 -> only hcount 1000..1023 draw ROM data (x addr 0..23), hcount 0..39 pass rgb_in.
REQ-031 Timing check: random hcount/hsync stream -> outputs equal inputs delayed exactly 3 clk.

Source files
------------

// File: rtl/draw_image_ctl.sv
// draw_image_ctl
//   Overlays a 64x64 image from an external synchronous ROM on a VGA pixel
//   stream. The image's top-left corner comes from xpos/ypos. That corner
//   is only taken in when vsync rises, so the image never tears mid-frame.
//   ROM pixels equal to KEY_RGB are transparent and show the background.
//   The pipeline is three clocks deep and accepts one pixel per clock:
//     E1: capture timing, background and window flag; register ROM address
//     E2: delay everything while the ROM looks up the pixel
//     E3: composite blank / ROM / background onto the outputs
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   hcount_in, vcount_in   [10:0]     VGA pixel counters
//   hsync_in, vsync_in               VGA sync strobes
//   hblnk_in, vblnk_in               VGA blanking strobes
//   rgb_in                 [11:0]     background pixel
//   xpos, ypos             [10:0]     requested image top-left corner
//   address                [11:0]     ROM address {y[5:0], x[5:0]}, registered
//   rgb_rom                [11:0]     ROM data, one clock after address
//   hcount_out .. vblnk_out           timing delayed by 3 clocks
//   rgb_out                [11:0]     composited pixel, aligned with timing
module draw_image_ctl #(
    parameter int          IMG_W   = 64,
    parameter int          IMG_H   = 64,
    parameter logic [11:0] KEY_RGB = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic [11:0] address,
    input  logic [11:0] rgb_rom,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Position latch
    logic [10:0] xpos_q, ypos_q;
    logic        vsync_prev;
    logic        vsync_rise;

    // Window decode. Everything is widened to 12 bits so that an image
    // hanging off the right/bottom edge does not wrap its upper bound.
    logic [11:0] x_lo, x_hi, y_lo, y_hi, h12, v12;
    logic        in_win;
    logic [5:0]  x_off, y_off;
    logic [11:0] address_nxt;

    // Pipeline stage 1
    logic [10:0] hcount_s1, vcount_s1;
    logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1, win_s1;
    logic [11:0] rgb_s1;

    // Pipeline stage 2
    logic [10:0] hcount_s2, vcount_s2;
    logic        hsync_s2, vsync_s2, hblnk_s2, vblnk_s2, win_s2;
    logic [11:0] rgb_s2;

    logic [11:0] rgb_nxt;

    assign vsync_rise = vsync_in & ~vsync_prev;

    // New position only takes effect on a vsync rising edge. Pixels sampled
    // on that same edge still see the old xpos_q/ypos_q below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos_q     <= 11'd0;
            ypos_q     <= 11'd0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_rise) begin
                xpos_q <= xpos;
                ypos_q <= ypos;
            end
        end
    end

    always_comb begin
        x_lo   = {1'b0, xpos_q};
        y_lo   = {1'b0, ypos_q};
        x_hi   = x_lo + 12'(IMG_W);
        y_hi   = y_lo + 12'(IMG_H);
        h12    = {1'b0, hcount_in};
        v12    = {1'b0, vcount_in};
        in_win = (h12 >= x_lo) && (h12 < x_hi) && (v12 >= y_lo) && (v12 < y_hi);
        // Only the low six bits of the offsets matter; the subtraction
        // modulo 64 equals the low bits of the full-width difference.
        x_off  = hcount_in[5:0] - xpos_q[5:0];
        y_off  = vcount_in[5:0] - ypos_q[5:0];
        address_nxt = in_win ? {y_off, x_off} : 12'h000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_s1 <= 11'd0;
            vcount_s1 <= 11'd0;
            hsync_s1  <= 1'b0;
            vsync_s1  <= 1'b0;
            hblnk_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            rgb_s1    <= 12'h000;
            win_s1    <= 1'b0;
            address   <= 12'h000;
            hcount_s2 <= 11'd0;
            vcount_s2 <= 11'd0;
            hsync_s2  <= 1'b0;
            vsync_s2  <= 1'b0;
            hblnk_s2  <= 1'b0;
            vblnk_s2  <= 1'b0;
            rgb_s2    <= 12'h000;
            win_s2    <= 1'b0;
        end else begin
            hcount_s1 <= hcount_in;
            vcount_s1 <= vcount_in;
            hsync_s1  <= hsync_in;
            vsync_s1  <= vsync_in;
            hblnk_s1  <= hblnk_in;
            vblnk_s1  <= vblnk_in;
            rgb_s1    <= rgb_in;
            win_s1    <= in_win;
            address   <= address_nxt;
            hcount_s2 <= hcount_s1;
            vcount_s2 <= vcount_s1;
            hsync_s2  <= hsync_s1;
            vsync_s2  <= vsync_s1;
            hblnk_s2  <= hblnk_s1;
            vblnk_s2  <= vblnk_s1;
            rgb_s2    <= rgb_s1;
            win_s2    <= win_s1;
        end
    end

    // rgb_rom belongs to the stage-2 pixel: its address was registered at E1
    // and the ROM returned the data during stage 2.
    always_comb begin
        rgb_nxt = rgb_s2;
        if (hblnk_s2 || vblnk_s2)
            rgb_nxt = 12'h000;
        else if (win_s2 && (rgb_rom != KEY_RGB))
            rgb_nxt = rgb_rom;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'h000;
        end else begin
            hcount_out <= hcount_s2;
            vcount_out <= vcount_s2;
            hsync_out  <= hsync_s2;
            vsync_out  <= vsync_s2;
            hblnk_out  <= hblnk_s2;
            vblnk_out  <= vblnk_s2;
            rgb_out    <= rgb_nxt;
        end
    end

endmodule
